// File: rtl/plic_gateway.sv
// plic_gateway: PLIC-style interrupt gateway, priority arbiter and claim/complete register block.
// Latency: ack one cycle after accept, irq_ext one cycle after max_id changes (+2 with PLIC_GATEWAY_SYNC_EN).
// Backpressure: one access in flight; the cycle holding ack never accepts a new request.
module plic_gateway #(
  parameter int N_SRC  = 8,
  parameter int PRIO_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] irq_src,
  input  logic             req,
  input  logic             we,
  input  logic [31:0]      addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  output logic             ack,
  output logic             irq_ext
);

  typedef enum logic {
    ST_IDLE,
    ST_ACK
  } bus_state_t;

  localparam logic [19:0] WIDX_PEND  = 20'h00400;
  localparam logic [19:0] WIDX_EN    = 20'h00800;
  localparam logic [19:0] WIDX_THR   = 20'h80000;
  localparam logic [19:0] WIDX_CLAIM = 20'h80001;

  bus_state_t        state;
  logic [N_SRC-1:0]  irq_s;
  logic [N_SRC:1]    pending;
  logic [N_SRC:1]    inflight;
  logic [N_SRC:1]    enable;
  logic [PRIO_W-1:0] prio [1:N_SRC];
  logic [PRIO_W-1:0] threshold;
  logic [PRIO_W-1:0] best_prio;
  logic [4:0]        max_id;
  logic [4:0]        cid;
  logic [19:0]       widx;
  logic [31:0]       rd_val;
  logic              accept;
  logic              wr_en;
  logic              sel_prio;
  logic              sel_pend;
  logic              sel_en;
  logic              sel_thr;
  logic              sel_claim;
  logic              do_claim;
  logic              do_complete;
  logic              unused_bits;

`ifdef PLIC_GATEWAY_SYNC_EN
  logic [N_SRC-1:0] sync_q1;
  logic [N_SRC-1:0] sync_q2;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= irq_src;
      sync_q2 <= sync_q1;
    end
  end

  assign irq_s = sync_q2;
`else
  assign irq_s = irq_src;
`endif

  assign widx        = addr[21:2];
  assign cid         = wdata[4:0];
  assign accept      = req && (state == ST_IDLE);
  assign wr_en       = accept && we;
  assign sel_prio    = widx < 20'(N_SRC + 1);
  assign sel_pend    = widx == WIDX_PEND;
  assign sel_en      = widx == WIDX_EN;
  assign sel_thr     = widx == WIDX_THR;
  assign sel_claim   = widx == WIDX_CLAIM;
  assign do_claim    = accept && !we && sel_claim && (max_id != 5'd0);
  assign do_complete = wr_en && sel_claim;
  assign unused_bits = ^{addr[31:22], addr[1:0], wdata};

  // Strict '>' keeps the lowest ID on equal priority; prio 0 can never beat threshold.
  always_comb begin
    max_id    = 5'd0;
    best_prio = '0;
    for (int i = 1; i <= N_SRC; i++) begin
      if (pending[i] && enable[i] && (prio[i] > threshold) && (prio[i] > best_prio)) begin
        best_prio = prio[i];
        max_id    = 5'(i);
      end
    end
  end

  always_comb begin
    rd_val = '0;
    if (sel_prio) begin
      for (int i = 1; i <= N_SRC; i++) begin
        if (widx == 20'(i)) rd_val[PRIO_W-1:0] = prio[i];
      end
    end else if (sel_pend) begin
      rd_val[N_SRC:1] = pending;
    end else if (sel_en) begin
      rd_val[N_SRC:1] = enable;
    end else if (sel_thr) begin
      rd_val[PRIO_W-1:0] = threshold;
    end else if (sel_claim) begin
      rd_val[4:0] = max_id;
    end
  end

  // A claim on the same edge as a new level sample wins for that source.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending  <= '0;
      inflight <= '0;
    end else begin
      for (int i = 1; i <= N_SRC; i++) begin
        if (do_claim && (max_id == 5'(i))) begin
          pending[i]  <= 1'b0;
          inflight[i] <= 1'b1;
        end else begin
          if (irq_s[i-1] && !pending[i] && !inflight[i]) pending[i] <= 1'b1;
          if (do_complete && (cid == 5'(i)) && inflight[i] && enable[i]) inflight[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      ack       <= 1'b0;
      rdata     <= '0;
      irq_ext   <= 1'b0;
      threshold <= '0;
      enable    <= '0;
      for (int i = 1; i <= N_SRC; i++) prio[i] <= '0;
    end else begin
      irq_ext <= (max_id != 5'd0);
      case (state)
        ST_IDLE: begin
          if (req) begin
            state <= ST_ACK;
            ack   <= 1'b1;
            rdata <= rd_val;
          end
        end
        ST_ACK: begin
          state <= ST_IDLE;
          ack   <= 1'b0;
          rdata <= '0;
        end
        default: state <= ST_IDLE;
      endcase
      if (wr_en) begin
        if (sel_prio) begin
          for (int i = 1; i <= N_SRC; i++) begin
            if (widx == 20'(i)) prio[i] <= wdata[PRIO_W-1:0];
          end
        end
        if (sel_en)  enable    <= wdata[N_SRC:1];
        if (sel_thr) threshold <= wdata[PRIO_W-1:0];
      end
    end
  end

endmodule
